// File: rtl/vector_stream_tx.sv
// Streams a loaded vector pair one element per beat; VECTOR_STREAM_TX_REVERSE_EN sends N-1..0.
// Latency: first beat valid 1 cycle after the load handshake, one beat per accepted cycle after.
// Backpressure: out_ready low holds the current beat stable; load_ready is low while streaming.
module vector_stream_tx #(
  parameter int N  = 3,
  parameter int W  = 3,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [N*W-1:0] vector1_flat,
  input  logic [N*W-1:0] vector2_flat,
  output logic [W-1:0]  number_vector1,
  output logic [W-1:0]  number_vector2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [CW-1:0] elem_index,
  output logic          done
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
`ifdef VECTOR_STREAM_TX_REVERSE_EN
  localparam logic [CW-1:0] FIRST_IDX = LAST_IDX;
  localparam logic [CW-1:0] FINAL_IDX = '0;
`else
  localparam logic [CW-1:0] FIRST_IDX = '0;
  localparam logic [CW-1:0] FINAL_IDX = LAST_IDX;
`endif

  state_t          state;
  logic [N*W-1:0]  v1_q;
  logic [N*W-1:0]  v2_q;
  logic [CW-1:0]   next_idx;

  // Only consumed when the current beat is not the final one, so no wrap is ever visible.
  always_comb begin
    next_idx = elem_index;
`ifdef VECTOR_STREAM_TX_REVERSE_EN
    next_idx = elem_index - CW'(1);
`else
    next_idx = elem_index + CW'(1);
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      load_ready     <= 1'b1;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      done           <= 1'b0;
      number_vector1 <= '0;
      number_vector2 <= '0;
      elem_index     <= '0;
      v1_q           <= '0;
      v2_q           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid && load_ready) begin
            v1_q           <= vector1_flat;
            v2_q           <= vector2_flat;
            number_vector1 <= vector1_flat[FIRST_IDX*W +: W];
            number_vector2 <= vector2_flat[FIRST_IDX*W +: W];
            elem_index     <= FIRST_IDX;
            out_last       <= (FIRST_IDX == FINAL_IDX);
            out_valid      <= 1'b1;
            load_ready     <= 1'b0;
            state          <= STREAM;
          end
        end
        STREAM: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              load_ready <= 1'b1;
              done       <= 1'b1;
              state      <= IDLE;
            end else begin
              elem_index     <= next_idx;
              number_vector1 <= v1_q[next_idx*W +: W];
              number_vector2 <= v2_q[next_idx*W +: W];
              out_last       <= (next_idx == FINAL_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_stream_tx.sv
// Directed table-driven bench for vector_stream_tx (N=3 instance plus an N=1 instance).
module tb_vector_stream_tx;

`ifdef VECTOR_STREAM_TX_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  localparam logic [11:0] MASK_ALL  = 12'hFFF;
  localparam logic [11:0] MASK_IDLE = 12'hC09;  // load_ready, out_valid, out_last, done

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic       load_valid, load_ready, out_valid, out_ready, out_last, done;
  logic [8:0] vector1_flat, vector2_flat;
  logic [2:0] number_vector1, number_vector2;
  logic [1:0] elem_index;

  logic       s_load_valid, s_load_ready, s_out_valid, s_out_ready, s_out_last, s_done;
  logic [2:0] s_vector1_flat, s_vector2_flat, s_nv1, s_nv2;
  logic [0:0] s_elem_index;

  vector_stream_tx #(.N(3), .W(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .load_valid(load_valid), .load_ready(load_ready),
    .vector1_flat(vector1_flat), .vector2_flat(vector2_flat),
    .number_vector1(number_vector1), .number_vector2(number_vector2),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .elem_index(elem_index), .done(done)
  );

  vector_stream_tx #(.N(1), .W(3)) dut_n1 (
    .clock(clock), .reset_n(reset_n),
    .load_valid(s_load_valid), .load_ready(s_load_ready),
    .vector1_flat(s_vector1_flat), .vector2_flat(s_vector2_flat),
    .number_vector1(s_nv1), .number_vector2(s_nv2),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_last(s_out_last),
    .elem_index(s_elem_index), .done(s_done)
  );

  logic [11:0] dut_out, n1_out;
  assign dut_out = {load_ready, out_valid, number_vector1, number_vector2, out_last, elem_index, done};
  assign n1_out  = {s_load_ready, s_out_valid, s_nv1, s_nv2, s_out_last, 1'b0, s_elem_index, s_done};

  typedef struct {
    logic        rst_n;
    logic        lv;
    logic [8:0]  v1;
    logic [8:0]  v2;
    logic        ordy;
    logic [11:0] exp;
    logic [11:0] mask;
    string       name;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [2:0] elem(input logic [8:0] f, input int idx);
    return f[idx*3 +: 3];
  endfunction

  // Expected outputs while beat k (in transmission order) is presented.
  function automatic logic [11:0] beat(input logic [8:0] a, input logic [8:0] b, input int k);
    int idx;
    idx = REV ? 2 - k : k;
    return {1'b0, 1'b1, elem(a, idx), elem(b, idx), (k == 2), 2'(idx), 1'b0};
  endfunction

  function automatic logic [11:0] idle(input logic d);
    return {1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 2'd0, d};
  endfunction

  function automatic void add(input logic r, input logic lv, input logic [8:0] a,
                              input logic [8:0] b, input logic o, input logic [11:0] e,
                              input logic [11:0] m, input string n);
    vec_t t;
    t.rst_n = r; t.lv = lv; t.v1 = a; t.v2 = b; t.ordy = o;
    t.exp = e; t.mask = m; t.name = n;
    tbl.push_back(t);
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp,
                       input logic [11:0] mask);
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      failures++;
      $display("FAIL %s: got %h expected %h (mask %h) at %0t", name, act, exp, mask, $time);
    end
  endtask

  initial begin
    logic [8:0] v1a, v2a, vx, vy;
    int         n;
    v1a = {3'd3, 3'd2, 3'd1};
    v2a = {3'd6, 3'd5, 3'd4};
    vx  = {3'd7, 3'd6, 3'd5};
    vy  = {3'd0, 3'd1, 3'd2};

    reset_n = 1'b0; load_valid = 1'b0; out_ready = 1'b0;
    vector1_flat = '0; vector2_flat = '0;
    s_load_valid = 1'b0; s_out_ready = 1'b0; s_vector1_flat = '0; s_vector2_flat = '0;

    // reset, including load_valid asserted while in reset
    add(0, 0, v1a, v2a, 1, idle(0), MASK_ALL, "t1_reset");
    add(0, 1, v1a, v2a, 1, idle(0), MASK_ALL, "t1_reset_lv");
    // back-to-back stream
    add(1, 1, v1a, v2a, 1, beat(v1a, v2a, 0), MASK_ALL, "t2_b0");
    add(1, 0, v1a, v2a, 1, beat(v1a, v2a, 1), MASK_ALL, "t2_b1");
    add(1, 0, v1a, v2a, 1, beat(v1a, v2a, 2), MASK_ALL, "t2_b2");
    add(1, 0, v1a, v2a, 1, idle(1), MASK_IDLE, "t2_done");
    add(1, 0, v1a, v2a, 1, idle(0), MASK_IDLE, "t2_quiet");
    // four-cycle stall on the second beat
    add(1, 1, v1a, v2a, 1, beat(v1a, v2a, 0), MASK_ALL, "t3_b0");
    add(1, 0, v1a, v2a, 1, beat(v1a, v2a, 1), MASK_ALL, "t3_b1");
    for (int i = 0; i < 4; i++)
      add(1, 0, v1a, v2a, 0, beat(v1a, v2a, 1), MASK_ALL, "t3_stall");
    add(1, 0, v1a, v2a, 1, beat(v1a, v2a, 2), MASK_ALL, "t3_b2");
    add(1, 0, v1a, v2a, 1, idle(1), MASK_IDLE, "t3_done");
    add(1, 0, v1a, v2a, 1, idle(0), MASK_IDLE, "t3_quiet");
    // load_valid held with new data during streaming
    add(1, 1, v1a, v2a, 1, beat(v1a, v2a, 0), MASK_ALL, "t4_b0");
    add(1, 1, vx, vy, 1, beat(v1a, v2a, 1), MASK_ALL, "t4_ign_b1");
    add(1, 1, vx, vy, 1, beat(v1a, v2a, 2), MASK_ALL, "t4_ign_b2");
    add(1, 1, vx, vy, 1, idle(1), MASK_IDLE, "t4_done");
    add(1, 1, vx, vy, 1, beat(vx, vy, 0), MASK_ALL, "t4_new_b0");
    // reset mid-vector, nothing resumes
    add(0, 0, vx, vy, 1, idle(0), MASK_ALL, "t5_reset");
    add(1, 0, vx, vy, 1, idle(0), MASK_ALL, "t5_no_resume");
    add(1, 0, vx, vy, 1, idle(0), MASK_ALL, "t5_no_resume");

    for (int i = 0; i < tbl.size(); i++) begin
      reset_n      = tbl[i].rst_n;
      load_valid   = tbl[i].lv;
      vector1_flat = tbl[i].v1;
      vector2_flat = tbl[i].v2;
      out_ready    = tbl[i].ordy;
      @(posedge clock); #1;
      check(tbl[i].name, dut_out, tbl[i].exp, tbl[i].mask);
    end

    // reset asserted between clock edges takes effect without an edge
    load_valid = 1'b1; vector1_flat = v1a; vector2_flat = v2a; out_ready = 1'b1;
    @(posedge clock); #1;
    check("async_b0", dut_out, beat(v1a, v2a, 0), MASK_ALL);
    load_valid = 1'b0;
    @(posedge clock); #1;
    check("async_b1", dut_out, beat(v1a, v2a, 1), MASK_ALL);
    #2 reset_n = 1'b0;
    #1 check("async_reset", dut_out, idle(0), MASK_ALL);
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("async_no_resume", {11'd0, out_valid}, 12'd0, MASK_ALL);
    end

    // single-element vector: first beat is also the last
    s_load_valid = 1'b1; s_vector1_flat = 3'd5; s_vector2_flat = 3'd7; s_out_ready = 1'b1;
    @(posedge clock); #1;
    check("n1_beat", n1_out, {1'b0, 1'b1, 3'd5, 3'd7, 1'b1, 2'd0, 1'b0}, MASK_ALL);
    s_load_valid = 1'b0;
    n = 0;
    while (!s_done && n < 4) begin
      @(posedge clock); #1;
      n++;
    end
    check("n1_done_latency", 12'(n), 12'd1, MASK_ALL);
    check("n1_idle", n1_out, {1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 2'd0, 1'b1}, MASK_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
